// File: rtl/uart_cmd_dec.sv
// Byte-stream command decoder behind the UART receiver: assembles 'W'/'R' frames
// (LSB-first address/data) into 32-bit bus commands, with an inter-byte timeout.
module uart_cmd_dec #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_data_vld_i,
  output logic        rx_data_rdy_o,
  output logic        cmd_vld_o,
  input  logic        cmd_rdy_i,
  output logic        cmd_we_o,
  output logic [31:0] cmd_addr_o,
  output logic [31:0] cmd_wdata_o,
  output logic        err_o,
  output logic        tmo_o
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ISSUE
  } state_e;

  localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic        accept;
  logic        expire;

  // Ready depends on state only, so no combinational path from vld or cmd_rdy.
  assign rx_data_rdy_o = (state_q != ISSUE);
  assign accept        = rx_data_vld_i && rx_data_rdy_o;
  assign expire        = (tcnt_q == TMO_LAST) && !accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = '0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (rx_data_i == OP_WRITE) begin
            we_d    = 1'b1;
            wdata_d = '0;
            state_d = ADDR;
          end else if (rx_data_i == OP_READ) begin
            we_d    = 1'b0;
            wdata_d = '0;
            state_d = ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ADDR: begin
        if (accept) begin
          addr_d = {rx_data_i, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = we_q ? DATA : ISSUE;
          end
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end

      DATA: begin
        if (accept) begin
          wdata_d = {rx_data_i, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ISSUE;
          end
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end

      ISSUE: begin
        if (cmd_rdy_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign cmd_vld_o   = (state_q == ISSUE);
  assign cmd_we_o    = we_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign tmo_o       = tmo_q;

endmodule

// File: tb/tb_uart_cmd_dec.sv
// Bench for uart_cmd_dec: directed scenarios plus random frames, checked every
// cycle against a frame-level reference model built on a byte queue.
module tb_uart_cmd_dec;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_rdy;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        err;
  logic        tmo;

  uart_cmd_dec #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rx_data_i    (rx_data),
    .rx_data_vld_i(rx_vld),
    .rx_data_rdy_o(rx_rdy),
    .cmd_vld_o    (cmd_vld),
    .cmd_rdy_i    (cmd_rdy),
    .cmd_we_o     (cmd_we),
    .cmd_addr_o   (cmd_addr),
    .cmd_wdata_o  (cmd_wdata),
    .err_o        (err),
    .tmo_o        (tmo)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference model: bytes of the frame in progress, idle edges, pending command.
  logic [7:0]  frame[$];
  int unsigned m_idle;
  logic        m_pend, m_acc, m_err, m_tmo, m_we;
  logic [31:0] m_addr, m_wdata;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_wdata[$];
  logic        cap_we[$];
  int unsigned err_seen, tmo_seen;
  logic        rnd_rdy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    m_idle = 0;
    m_pend = 1'b0;
    m_acc  = 1'b0;
    m_err  = 1'b0;
    m_tmo  = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned need;
    m_acc = 1'b0;
    m_err = 1'b0;
    m_tmo = 1'b0;
    if (m_pend) begin
      if (cmd_rdy) m_pend = 1'b0;
    end else if (rx_vld) begin
      m_acc  = 1'b1;
      m_idle = 0;
      frame.push_back(rx_data);
      if (frame[0] != 8'h57 && frame[0] != 8'h52) begin
        m_err = 1'b1;
        frame.delete();
      end else begin
        need = (frame[0] == 8'h57) ? 9 : 5;
        if (frame.size() == need) begin
          m_we    = (frame[0] == 8'h57);
          m_addr  = 0;
          m_wdata = 0;
          for (int k = 0; k < 4; k++) begin
            m_addr = m_addr + (32'(frame[1+k]) << (8*k));
            if (m_we) m_wdata = m_wdata + (32'(frame[5+k]) << (8*k));
          end
          m_pend = 1'b1;
          frame.delete();
        end
      end
    end else if (frame.size() != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_tmo  = 1'b1;
        m_idle = 0;
        frame.delete();
      end
    end
  endtask

  task automatic step();
    if (cmd_vld && cmd_rdy) begin
      cap_addr.push_back(cmd_addr);
      cap_wdata.push_back(cmd_wdata);
      cap_we.push_back(cmd_we);
    end
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rx_rdy", rx_rdy, !m_pend);
    check_eq("cmd_vld", cmd_vld, m_pend);
    check_eq("err", err, m_err);
    check_eq("tmo", tmo, m_tmo);
    if (m_pend) begin
      check_eq("cmd_we", cmd_we, m_we);
      check_eq("cmd_addr", cmd_addr, m_addr);
      check_eq("cmd_wdata", cmd_wdata, m_wdata);
    end
    if (err) err_seen++;
    if (tmo) tmo_seen++;
    if (rnd_rdy) cmd_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_byte(input logic [7:0] b, input int unsigned gap, output int unsigned waited);
    rx_data = b;
    rx_vld  = 1'b1;
    waited  = 0;
    do begin
      step();
      waited++;
    end while (!m_acc && waited < 200);
    if (!m_acc) check_eq("accept_bound", m_acc, 1'b1);
    rx_vld = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    int unsigned w;
    push_byte(b, gap, w);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input int unsigned tail);
    logic [31:0] av, dv;
    av = a;
    dv = d;
    send(8'h57, 0);
    for (int k = 0; k < 4; k++) send(av[8*k +: 8], 0);
    for (int k = 0; k < 4; k++) send(dv[8*k +: 8], (k == 3) ? tail : 0);
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_wdata.delete();
    cap_we.delete();
    err_seen = 0;
    tmo_seen = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_vld"}, cmd_vld, 1'b0);
    check_eq({tag, "_we"}, cmd_we, 1'b0);
    check_eq({tag, "_addr"}, cmd_addr, 32'h0);
    check_eq({tag, "_wdata"}, cmd_wdata, 32'h0);
    check_eq({tag, "_err"}, err, 1'b0);
    check_eq({tag, "_tmo"}, tmo, 1'b0);
    check_eq({tag, "_rdy"}, rx_rdy, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w, vcnt, first, n, trunc, gap, opsel;
    logic [7:0]  op, b;
    logic [31:0] sa[3], sd[3];

    rst_n   = 1'b0;
    rx_data = '0;
    rx_vld  = 1'b0;
    cmd_rdy = 1'b1;
    rnd_rdy = 1'b0;
    model_reset();
    clear_caps();
    #3;
    check_reset_outputs("reset");
    #9 rst_n = 1'b1;

    // Write frame
    clear_caps();
    send_write(32'h12345678, 32'hDEADBEEF, 2);
    check_eq("wr_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      check_eq("wr_we", cap_we[0], 1'b1);
      check_eq("wr_addr", cap_addr[0], 32'h12345678);
      check_eq("wr_wdata", cap_wdata[0], 32'hDEADBEEF);
    end

    // Read frame with backpressure and a byte waiting behind it
    clear_caps();
    cmd_rdy = 1'b0;
    send(8'h52, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0); send(8'h80, 0);
    rx_data = 8'h57;
    rx_vld  = 1'b1;
    vcnt    = 0;
    repeat (10) begin
      if (cmd_vld) vcnt++;
      step();
    end
    cmd_rdy = 1'b1;
    if (cmd_vld) vcnt++;
    step();
    if (cmd_vld) vcnt++;
    check_eq("bp_vld_cycles", vcnt, 11);
    push_byte(8'h57, 0, w);
    check_eq("bp_pending_wait", w, 1);
    for (int k = 0; k < 8; k++) send(8'(k + 1), (k == 7) ? 2 : 0);
    check_eq("bp_count", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      check_eq("bp_addr", cap_addr[0], 32'h80001000);
      check_eq("bp_we", cap_we[0], 1'b0);
      check_eq("bp_wdata", cap_wdata[0], 32'h0);
      check_eq("bp_next_addr", cap_addr[1], 32'h04030201);
      check_eq("bp_next_wdata", cap_wdata[1], 32'h08070605);
    end

    // Bad opcode followed by a read
    clear_caps();
    send(8'h00, 0);
    send(8'h52, 0); send(8'h04, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 2);
    check_eq("bad_err_pulses", err_seen, 1);
    check_eq("bad_tmo_pulses", tmo_seen, 0);
    check_eq("bad_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      check_eq("bad_addr", cap_addr[0], 32'h00000004);
      check_eq("bad_we", cap_we[0], 1'b0);
    end

    // Timeout after a partial write frame
    clear_caps();
    send(8'h57, 0); send(8'h11, 0); send(8'h22, 0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tmo && first == 0) first = i;
    end
    check_eq("tmo_latency", first, TMO);
    check_eq("tmo_pulses", tmo_seen, 1);
    check_eq("tmo_rdy_idle", rx_rdy, 1'b1);
    send(8'h52, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 2);
    check_eq("tmo_rd_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) check_eq("tmo_rd_addr", cap_addr[0], 32'h00000001);

    // Byte arriving on the expiry cycle wins over the timeout
    clear_caps();
    send(8'h57, 0); send(8'h11, 0);
    send(8'h22, TMO - 1);
    push_byte(8'h33, 0, w);
    check_eq("edge_wait", w, 1);
    send(8'h44, 0); send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 2);
    check_eq("edge_tmo_pulses", tmo_seen, 0);
    check_eq("edge_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      check_eq("edge_addr", cap_addr[0], 32'h44332211);
      check_eq("edge_wdata", cap_wdata[0], 32'h88776655);
    end

    // Asynchronous reset in DATA after three data bytes
    clear_caps();
    send(8'h57, 0);
    for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), 0);
    for (int k = 0; k < 3; k++) send(8'hB0 + 8'(k), 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("midrst");
    #10 rst_n = 1'b1;
    #1 check_eq("midrst_rdy_rel", rx_rdy, 1'b1);
    send_write(32'hCAFEF00D, 32'h0BADC0DE, 2);
    check_eq("midrst_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      check_eq("midrst_addr", cap_addr[0], 32'hCAFEF00D);
      check_eq("midrst_wdata", cap_wdata[0], 32'h0BADC0DE);
    end

    // Three back-to-back write frames
    clear_caps();
    for (int f = 0; f < 3; f++) begin
      sa[f] = $urandom;
      sd[f] = $urandom;
    end
    for (int f = 0; f < 3; f++) send_write(sa[f], sd[f], (f == 2) ? 2 : 0);
    check_eq("stream_count", cap_addr.size(), 3);
    if (cap_addr.size() == 3) begin
      for (int f = 0; f < 3; f++) begin
        check_eq("stream_addr", cap_addr[f], sa[f]);
        check_eq("stream_wdata", cap_wdata[f], sd[f]);
        check_eq("stream_we", cap_we[f], 1'b1);
      end
    end

    // Random frames: bad opcodes, truncations, long gaps, random cmd_rdy
    rnd_rdy = 1'b1;
    for (int f = 0; f < 250; f++) begin
      opsel = $urandom_range(0, 9);
      if (opsel == 0) begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
        n = 1;
      end else if (opsel <= 5) begin
        op = 8'h57;
        n = 9;
      end else begin
        op = 8'h52;
        n = 5;
      end
      trunc = n;
      if (n > 1 && $urandom_range(0, 7) == 0) trunc = $urandom_range(1, n - 1);
      for (int j = 0; j < trunc; j++) begin
        b = (j == 0) ? op : 8'($urandom);
        gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 3, TMO + 1) : $urandom_range(0, 1);
        if (j == trunc - 1 && trunc < n) gap = TMO + 2;
        send(b, gap);
      end
    end
    rnd_rdy = 1'b0;
    cmd_rdy = 1'b1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
